rr_priority_arbiter4: RTL and testbench

- Four-requester round-robin arbiter built around LSB-first priority encoding.
- The search starts at a rotating pointer instead of fixed bit 0, so no requester starves.
- The winner keeps its grant until it drops its request or a hold limit expires.
- Shares a single downstream resource (bus, encoder output channel, shared register) between four clients.

---
 rtl/rr_priority_arbiter4.sv | 126 ++++++++++++
 tb/tb_rr_priority_arbiter4.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter4.sv
// Four-requester round-robin arbiter: LSB-first search starting at a rotating
// pointer, grant held until the owner drops its request or the hold limit hits.
module rr_priority_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       id_q, id_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  logic [3:0]       req_c;
  logic             found;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             drop;
  logic             limit;

  // An unknown request bit takes the else branch, so it never wins arbitration.
  always_comb begin
    req_c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (req[k]) req_c[k] = 1'b1;
      else        req_c[k] = 1'b0;
    end
  end

  // Rotated LSB-first priority encode: scan ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req_c[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    drop  = !req_c[id_q];
    limit = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          id_d    = winner;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (drop || limit) begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          ptr_d   = id_q + 2'd1;
          cnt_d   = '0;
          to_d    = limit && !drop;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = |gnt_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_priority_arbiter4.sv
// Directed bench: instance A uses MAX_HOLD=4, instance B uses MAX_HOLD=0 (unlimited).
module tb_rr_priority_arbiter4;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, busy_b, to_a, to_b;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a),
    .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a), .timeout(to_a)
  );

  rr_priority_arbiter4 #(.MAX_HOLD(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b),
    .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b), .timeout(to_b)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b ({gnt,id,busy,timeout})", tag, got, exp);
    end
  endtask

  task automatic expect_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                          input logic to);
    check(tag, {gnt_a, id_a, busy_a, to_a}, {g, id, |g, to});
  endtask

  task automatic expect_b(input string tag, input logic [3:0] g, input logic [1:0] id,
                          input logic to);
    check(tag, {gnt_b, id_b, busy_b, to_b}, {g, id, |g, to});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rot_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 4'b1111; req_b = 4'b1111;
    #1;
    // Reset then idle
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_a("reset_a", 4'b0000, 2'd0, 1'b0);
      expect_b("reset_b", 4'b0000, 2'd0, 1'b0);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = 4'b0000; req_b = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_a("idle_a", 4'b0000, 2'd0, 1'b0);
      expect_b("idle_b", 4'b0000, 2'd0, 1'b0);
    end

    // Basic LSB priority from ptr=0
    req_a = 4'b1010;
    tick(); expect_a("lsb_win1", 4'b0010, 2'd1, 1'b0);
    req_a = 4'b1000;
    tick(); expect_a("lsb_bubble", 4'b0000, 2'd0, 1'b0);
    tick(); expect_a("lsb_win3", 4'b1000, 2'd3, 1'b0);
    req_a = 4'b0000;
    tick(); expect_a("lsb_release", 4'b0000, 2'd0, 1'b0);

    // Timeout: ptr=0 now, single requester 2 held for the limit
    req_a = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_a("to_hold", 4'b0100, 2'd2, 1'b0);
    end
    tick(); expect_a("to_pulse", 4'b0000, 2'd0, 1'b1);
    tick(); expect_a("to_regrant", 4'b0100, 2'd2, 1'b0);
    req_a = 4'b0000;
    tick(); expect_a("to_drop", 4'b0000, 2'd0, 1'b0);

    // Simultaneous drop and limit: ptr=3, owner 0 drops when hold_cnt==4
    req_a = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_a("sim_hold", 4'b0001, 2'd0, 1'b0);
    end
    req_a = 4'b0000;
    tick(); expect_a("sim_release", 4'b0000, 2'd0, 1'b0);
    req_a = 4'b0011;
    tick(); expect_a("sim_ptr1", 4'b0010, 2'd1, 1'b0);
    req_a = 4'b0000;
    tick(); expect_a("sim_drop", 4'b0000, 2'd0, 1'b0);

    // Reset mid-grant: ptr=2, owner 3
    req_a = 4'b1000;
    tick(); expect_a("rmg_grant3", 4'b1000, 2'd3, 1'b0);
    #3 rst_a = 1'b1;
    #1 expect_a("rmg_async3", 4'b0000, 2'd0, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b0; req_a = 4'b1001;
    tick(); expect_a("rmg_ptr0_a", 4'b0001, 2'd0, 1'b0);
    req_a = 4'b0000;
    tick(); expect_a("rmg_drop0", 4'b0000, 2'd0, 1'b0);
    req_a = 4'b0010;
    tick(); expect_a("rmg_grant1", 4'b0010, 2'd1, 1'b0);
    #3 rst_a = 1'b1;
    #1 expect_a("rmg_async1", 4'b0000, 2'd0, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b0; req_a = 4'b0011;
    tick(); expect_a("rmg_ptr0_b", 4'b0001, 2'd0, 1'b0);
    req_a = 4'b0000;
    tick(); expect_a("rmg_idle", 4'b0000, 2'd0, 1'b0);

    // Rotation on the unlimited instance: each owner holds 3 cycles, drops for one
    req_b = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 3; c++) begin
        tick(); expect_b("rot_hold", rot_exp[g], rot_id[g], 1'b0);
      end
      req_b = 4'b1111 & ~rot_exp[g];
      tick(); expect_b("rot_gap", 4'b0000, 2'd0, 1'b0);
      req_b = 4'b1111;
    end
    // Wrap back to owner 0, then hold well past any finite limit
    for (int c = 0; c < 12; c++) begin
      tick(); expect_b("rot_unlimited", rot_exp[4], rot_id[4], 1'b0);
    end
    req_b = 4'b0000;
    tick(); expect_b("rot_end", 4'b0000, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
